calc1_port_sequencer: RTL

CALC1_PORT_SEQUENCER -- requirements
Module: calc1_port_sequencer

---
 rtl/calc1_port_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/calc1_port_sequencer.sv
// Queues calc1 transactions and plays them one at a time onto a calc1 port:
// command + op1, then op2, then waits for a response or a timeout.
module calc1_port_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        push_valid,
   output logic        push_ready,
   input  logic [0:3]  push_cmd,
   input  logic [0:31] push_op1,
   input  logic [0:31] push_op2,
   output logic [0:3]  req_cmd_out,
   output logic [0:31] req_data_out,
   input  logic [0:1]  out_resp_in,
   input  logic [0:31] out_data_in,
   output logic        cpl_valid,
   output logic [0:3]  cpl_cmd,
   output logic [0:1]  cpl_resp,
   output logic [0:31] cpl_data,
   output logic        timeout_err,
   output logic        spurious_err,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, OP1, OP2, WAIT} state_t;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
   } entry_t;

   entry_t          mem_q [DEPTH];
   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TW-1:0]   wcnt_q, wcnt_d;
   entry_t          fl_q, fl_d;
   logic [3:0]      req_cmd_q, req_cmd_d;
   logic [31:0]     req_data_q, req_data_d;
   logic            cpl_valid_q, cpl_valid_d;
   logic [3:0]      cpl_cmd_q, cpl_cmd_d;
   logic [1:0]      cpl_resp_q, cpl_resp_d;
   logic [31:0]     cpl_data_q, cpl_data_d;
   logic            tmo_q, tmo_d, spur_q, spur_d;
   logic            busy_q, busy_d, ready_q, ready_d;
   logic            push_en, pop_en;
   entry_t          head;

   assign head = mem_q[rd_ptr_q];

   // Next-state, queue bookkeeping and registered port values
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      wcnt_d      = wcnt_q;
      fl_d        = fl_q;
      req_cmd_d   = '0;
      req_data_d  = '0;
      cpl_valid_d = 1'b0;
      cpl_cmd_d   = cpl_cmd_q;
      cpl_resp_d  = cpl_resp_q;
      cpl_data_d  = cpl_data_q;
      tmo_d       = tmo_q;
      spur_d      = spur_q;
      push_en     = push_valid && ready_q;
      pop_en      = 1'b0;

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop_en     = 1'b1;
               fl_d       = head;
               req_cmd_d  = head.cmd;
               req_data_d = head.op1;
               state_d    = OP1;
            end
         end
         OP1: begin
            req_data_d = fl_q.op2;
            state_d    = OP2;
         end
         OP2: begin
            wcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A response on the timeout cycle still wins over the timeout
            if (out_resp_in != 2'b00) begin
               cpl_valid_d = 1'b1;
               cpl_cmd_d   = fl_q.cmd;
               cpl_resp_d  = out_resp_in;
               cpl_data_d  = out_data_in;
               state_d     = IDLE;
            end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
               cpl_valid_d = 1'b1;
               cpl_cmd_d   = fl_q.cmd;
               cpl_resp_d  = '0;
               cpl_data_d  = '0;
               tmo_d       = 1'b1;
               state_d     = IDLE;
            end else begin
               wcnt_d = wcnt_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != WAIT && out_resp_in != 2'b00) spur_d = 1'b1;

      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
      ready_d = (count_d != CW'(DEPTH));
      busy_d  = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge c_clk) begin
      if (push_en) mem_q[wr_ptr_q] <= {push_cmd, push_op1, push_op2};
   end

   always_ff @(posedge c_clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wcnt_q      <= '0;
         fl_q        <= '0;
         req_cmd_q   <= '0;
         req_data_q  <= '0;
         cpl_valid_q <= 1'b0;
         cpl_cmd_q   <= '0;
         cpl_resp_q  <= '0;
         cpl_data_q  <= '0;
         tmo_q       <= 1'b0;
         spur_q      <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wcnt_q      <= wcnt_d;
         fl_q        <= fl_d;
         req_cmd_q   <= req_cmd_d;
         req_data_q  <= req_data_d;
         cpl_valid_q <= cpl_valid_d;
         cpl_cmd_q   <= cpl_cmd_d;
         cpl_resp_q  <= cpl_resp_d;
         cpl_data_q  <= cpl_data_d;
         tmo_q       <= tmo_d;
         spur_q      <= spur_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign push_ready   = ready_q;
   assign req_cmd_out  = req_cmd_q;
   assign req_data_out = req_data_q;
   assign cpl_valid    = cpl_valid_q;
   assign cpl_cmd      = cpl_cmd_q;
   assign cpl_resp     = cpl_resp_q;
   assign cpl_data     = cpl_data_q;
   assign timeout_err  = tmo_q;
   assign spurious_err = spur_q;
   assign busy         = busy_q;

endmodule
